rst_sequencer: RTL and testbench

Reset sequencer between the board/testbench reset source and the RS5 core reset input. Takes the raw asynchronous active-low reset and synchronizes its deassertion. Holds the CPU in reset for a programmable number of cycles, then releases it. Also services a software reset request handshake and records the cause of the last reset for the core to read.

---
 rtl/rst_sequencer.sv | 179 +++++++++++++++++
 tb/tb_rst_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
// rst_sequencer: reset sequencer between the board reset source and the CPU.
// Synchronizes rst_ni deassertion, holds the CPU in reset for HOLD_CYCLES,
// services a software reset handshake and records the last reset cause.
// Optional watchdog: define RST_WATCHDOG_EN to add wdt_kick_i and the
// watchdog timeout path (cause 2'b10). Without it the cause never reads 10.
module rst_sequencer #(
   parameter int SYNC_STAGES    = 2,
   parameter int HOLD_CYCLES    = 10,
   parameter int SW_HOLD_CYCLES = 4,
   parameter int WDT_TIMEOUT    = 1024
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       sw_rst_req_i,
   output logic       sw_rst_ack_o,
   output logic       rst_cpu_o,
   output logic       rst_cpu_no,
   output logic       ready_o,
   output logic [1:0] rst_cause_o
`ifdef RST_WATCHDOG_EN
   ,
   input  logic       wdt_kick_i
`endif
);

   // One shared counter serves HOLD, SW_HOLD and (optionally) the watchdog.
   localparam int MAX_HS  = (HOLD_CYCLES > SW_HOLD_CYCLES) ? HOLD_CYCLES : SW_HOLD_CYCLES;
   localparam int MAX_CNT = (MAX_HS > WDT_TIMEOUT) ? MAX_HS : WDT_TIMEOUT;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] SW_HOLD_LAST = CNT_W'(SW_HOLD_CYCLES - 1);

   localparam logic [1:0] CAUSE_POR = 2'b00;
   localparam logic [1:0] CAUSE_SW  = 2'b01;
`ifdef RST_WATCHDOG_EN
   localparam logic [1:0] CAUSE_WDT = 2'b10;
   localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_TIMEOUT - 1);
`endif

   // Reject illegal configurations at elaboration time.
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_chk_sync
      $error("rst_sequencer: SYNC_STAGES must be in 2..4");
   end
   if (HOLD_CYCLES < 1) begin : g_chk_hold
      $error("rst_sequencer: HOLD_CYCLES must be >= 1");
   end
   if (SW_HOLD_CYCLES < 1) begin : g_chk_sw_hold
      $error("rst_sequencer: SW_HOLD_CYCLES must be >= 1");
   end
   if (WDT_TIMEOUT < 2) begin : g_chk_wdt
      $error("rst_sequencer: WDT_TIMEOUT must be >= 2");
   end

   typedef enum logic [1:0] {
      ST_ASSERT,
      ST_HOLD,
      ST_RUN,
      ST_SW_HOLD
   } state_e;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [1:0]             cause_q, cause_d;
   logic                   ack_q, ack_d;
   logic                   rst_cpu_q, rst_cpu_d;
   logic                   req_armed_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   release_edge;
   logic                   sw_accept;

   // Deassertion synchronizer: a constant 1 ripples through the chain.
   // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   // The last flop captures 1 on this edge; the sequencer leaves ASSERT on the same edge.
   assign release_edge = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];

   // A request is accepted only in RUN and only after it has been seen low.
   assign sw_accept = (state_q == ST_RUN) && sw_rst_req_i && req_armed_q;

   // Next-state, counter, cause and acknowledge logic.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      ack_d   = 1'b0;

      unique case (state_q)
         ST_ASSERT: begin
            cnt_d = '0;
            if (release_edge) begin
               state_d = ST_HOLD;
            end
         end

         ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_RUN: begin
            if (sw_accept) begin
               state_d = ST_SW_HOLD;
               cnt_d   = '0;
               cause_d = CAUSE_SW;
               ack_d   = 1'b1;
            end
`ifdef RST_WATCHDOG_EN
            else if (wdt_kick_i) begin
               cnt_d = '0;
            end else if (cnt_q == WDT_LAST) begin
               state_d = ST_SW_HOLD;
               cnt_d   = '0;
               cause_d = CAUSE_WDT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end

         ST_SW_HOLD: begin
            if (cnt_q == SW_HOLD_LAST) begin
               // Counter saturates here until the request drops.
               if (!sw_rst_req_i) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
         end
      endcase

      rst_cpu_d = (state_d != ST_RUN);
   end

   // State and registered outputs; rst_ni forces the power-on condition at once.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_ASSERT;
         cnt_q       <= '0;
         cause_q     <= CAUSE_POR;
         ack_q       <= 1'b0;
         rst_cpu_q   <= 1'b1;
         req_armed_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cause_q     <= cause_d;
         ack_q       <= ack_d;
         rst_cpu_q   <= rst_cpu_d;
         req_armed_q <= ~sw_rst_req_i;
      end
   end

   assign rst_cpu_o    = rst_cpu_q;
   assign rst_cpu_no   = ~rst_cpu_q;
   assign ready_o      = (state_q == ST_RUN);
   assign sw_rst_ack_o = ack_q;
   assign rst_cause_o  = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: directed bench for rst_sequencer at default timing
// (2 sync stages, 10 hold cycles, 4 software hold cycles, watchdog 16).
module tb_rst_sequencer;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b1;
   logic       sw_rst_req_i = 1'b0;
   logic       sw_rst_ack_o;
   logic       rst_cpu_o;
   logic       rst_cpu_no;
   logic       ready_o;
   logic [1:0] rst_cause_o;
`ifdef RST_WATCHDOG_EN
   logic       wdt_kick_i = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] POR = 2'b00;
   localparam logic [1:0] SW  = 2'b01;
`ifdef RST_WATCHDOG_EN
   localparam logic [1:0] WDT = 2'b10;
`endif

   always #5 clk_i = ~clk_i;

   rst_sequencer #(
      .SYNC_STAGES   (2),
      .HOLD_CYCLES   (10),
      .SW_HOLD_CYCLES(4),
      .WDT_TIMEOUT   (16)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .sw_rst_req_i(sw_rst_req_i),
      .sw_rst_ack_o(sw_rst_ack_o),
      .rst_cpu_o   (rst_cpu_o),
      .rst_cpu_no  (rst_cpu_no),
      .ready_o     (ready_o),
      .rst_cause_o (rst_cause_o)
`ifdef RST_WATCHDOG_EN
      ,
      .wdt_kick_i  (wdt_kick_i)
`endif
   );

   // Expected output vector {rst_cpu, rst_cpu_n, ready, ack, cause}.
   function automatic logic [5:0] expv(input logic rst, input logic rdy,
                                       input logic ack, input logic [1:0] cause);
      return {rst, ~rst, rdy, ack, cause};
   endfunction

   function automatic logic [5:0] obs();
      return {rst_cpu_o, rst_cpu_no, ready_o, sw_rst_ack_o, rst_cause_o};
   endfunction

   // Advance one clock and sample 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Release rst_ni mid-cycle and check the 12-edge power-on sequence.
   task automatic power_on(input string tag);
      logic [5:0] e;
      #3 rst_ni = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         e = (k < 12) ? expv(1'b1, 1'b0, 1'b0, POR) : expv(1'b0, 1'b1, 1'b0, POR);
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL %s edge %0d: got %b expected %b", tag, k, obs(), e);
         end
      end
   endtask

   task automatic test_reset();
      logic [5:0] e;
      rst_ni = 1'b0;
      #1;
      e = expv(1'b1, 1'b0, 1'b0, POR);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL reset_async: got %b expected %b", obs(), e);
      end
      repeat (10) tick();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL reset_held: got %b expected %b", obs(), e);
      end
   endtask

   task automatic test_sw_pulse();
      logic [5:0] e;
      sw_rst_req_i = 1'b1;
      tick();
      sw_rst_req_i = 1'b0;
      e = expv(1'b1, 1'b0, 1'b1, SW);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL sw_pulse_accept: got %b expected %b", obs(), e);
      end
      for (int k = 1; k <= 4; k++) begin
         tick();
         e = (k < 4) ? expv(1'b1, 1'b0, 1'b0, SW) : expv(1'b0, 1'b1, 1'b0, SW);
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL sw_pulse_hold edge %0d: got %b expected %b", k, obs(), e);
         end
      end
   endtask

   task automatic test_held_req();
      logic [5:0] e;
      sw_rst_req_i = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         e = expv(1'b1, 1'b0, (k == 1), SW);
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL held_req cycle %0d: got %b expected %b", k, obs(), e);
         end
      end
      sw_rst_req_i = 1'b0;
      e = expv(1'b0, 1'b1, 1'b0, SW);
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL held_release cycle %0d: got %b expected %b", k, obs(), e);
         end
      end
   endtask

   task automatic test_reset_in_sw_hold();
      logic [5:0] e;
      sw_rst_req_i = 1'b1;
      tick();
      sw_rst_req_i = 1'b0;
      tick();
      #2 rst_ni = 1'b0;
      #1;
      e = expv(1'b1, 1'b0, 1'b0, POR);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL sw_hold_async: got %b expected %b", obs(), e);
      end
      repeat (10) tick();
      power_on("por_after_sw_hold");
   endtask

   task automatic test_reset_in_hold();
      logic [5:0] e;
      e = expv(1'b1, 1'b0, 1'b0, POR);
      rst_ni = 1'b0;
      #1;
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL run_async: got %b expected %b", obs(), e);
      end
      repeat (10) tick();
      #3 rst_ni = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL hold_pre edge %0d: got %b expected %b", k, obs(), e);
         end
      end
      // HOLD counter is now 5.
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL hold_async: got %b expected %b", obs(), e);
      end
      repeat (10) tick();
      power_on("por_after_hold");
   endtask

   task automatic test_ignored_req();
      logic [5:0] e;
      rst_ni = 1'b0;
      sw_rst_req_i = 1'b1;
      repeat (10) tick();
      power_on("por_req_held");
      e = expv(1'b0, 1'b1, 1'b0, POR);
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL held_req_ignored cycle %0d: got %b expected %b", k, obs(), e);
         end
      end
      sw_rst_req_i = 1'b0;
      tick();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL req_drop: got %b expected %b", obs(), e);
      end
      sw_rst_req_i = 1'b1;
      tick();
      sw_rst_req_i = 1'b0;
      e = expv(1'b1, 1'b0, 1'b1, SW);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL req_reaccept: got %b expected %b", obs(), e);
      end
      repeat (4) tick();
      e = expv(1'b0, 1'b1, 1'b0, SW);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL req_reaccept_done: got %b expected %b", obs(), e);
      end
   endtask

`ifdef RST_WATCHDOG_EN
   task automatic test_watchdog();
      logic [5:0] e;
      // No kick: timeout 16 cycles after entering RUN.
      for (int k = 1; k <= 16; k++) begin
         tick();
         e = (k < 16) ? expv(1'b0, 1'b1, 1'b0, SW) : expv(1'b1, 1'b0, 1'b0, WDT);
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL wdt_timeout edge %0d: got %b expected %b", k, obs(), e);
         end
      end
      repeat (4) tick();
      e = expv(1'b0, 1'b1, 1'b0, WDT);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL wdt_recover: got %b expected %b", obs(), e);
      end
      // Kick every 8 cycles: never times out.
      for (int k = 1; k <= 40; k++) begin
         wdt_kick_i = (k % 8 == 0);
         tick();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL wdt_kicked cycle %0d: got %b expected %b", k, obs(), e);
         end
      end
      wdt_kick_i = 1'b0;
      // Kick on the timeout cycle keeps RUN.
      repeat (15) tick();
      wdt_kick_i = 1'b1;
      tick();
      wdt_kick_i = 1'b0;
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL wdt_kick_at_timeout: got %b expected %b", obs(), e);
      end
      // Software request on the timeout cycle wins.
      repeat (15) tick();
      sw_rst_req_i = 1'b1;
      tick();
      sw_rst_req_i = 1'b0;
      e = expv(1'b1, 1'b0, 1'b1, SW);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL wdt_sw_wins: got %b expected %b", obs(), e);
      end
      repeat (4) tick();
      e = expv(1'b0, 1'b1, 1'b0, SW);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL wdt_sw_wins_done: got %b expected %b", obs(), e);
      end
   endtask
`endif

   initial begin
      #2;
      test_reset();
      power_on("power_on");
      test_sw_pulse();
      test_held_req();
      test_reset_in_sw_hold();
      test_reset_in_hold();
      test_ignored_req();
`ifdef RST_WATCHDOG_EN
      test_watchdog();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
